// File: rtl/dotl_checker.sv
// Passive sequence checker for a dice / traffic-light block: tracks the previous
// registered result and flags any step that the monitored block could not have made.
module dotl_checker #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             button,
   input  logic [2:0]       result,
   input  logic             clr,
   output logic             err,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_count,
   output logic [6:0]       pips,
   output logic             dbg_state
);

   typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [2:0]       prev_result_q;
   logic             prev_button_q, prev_sel_q;
   logic             err_q, err_d;
   logic             mismatch_q, mismatch_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       pips_q, pips_d;

   logic [2:0]       expected;
   logic             compare_en;
   logic             violation;

   function automatic logic is_legal(input logic s, input logic [2:0] r);
      if (s) return (r == 3'b100) || (r == 3'b110) || (r == 3'b001) || (r == 3'b010);
      else   return (r != 3'd0) && (r != 3'd7);
   endfunction

   // Successor of a legal code; illegal codes map to the block's recovery value.
   function automatic logic [2:0] next_code(input logic s, input logic [2:0] r);
      if (s) begin
         case (r)
            3'b100:  return 3'b110;
            3'b110:  return 3'b001;
            3'b001:  return 3'b010;
            default: return 3'b100;
         endcase
      end else begin
         if (!is_legal(1'b0, r) || r == 3'd6) return 3'd1;
         else                                 return r + 3'd1;
      end
   endfunction

   function automatic logic [6:0] face(input logic [2:0] v);
      case (v)
         3'd1:    return 7'b0001000;
         3'd2:    return 7'b1000001;
         3'd3:    return 7'b1001001;
         3'd4:    return 7'b1100011;
         3'd5:    return 7'b1101011;
         default: return 7'b1110111;
      endcase
   endfunction

   // A mode switch suppresses the comparison, behaving as a resync for that sample.
   always_comb begin
      expected = prev_result_q;
      if (!is_legal(sel, prev_result_q) || sel || prev_button_q)
         expected = next_code(sel, prev_result_q);
      compare_en = (state_q == TRACK) && (sel == prev_sel_q);
      violation  = compare_en && ((result != expected) || !is_legal(sel, result));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= SYNC;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC:    state_d = TRACK;
         TRACK:   state_d = TRACK;
         default: state_d = SYNC;
      endcase
   end

   always_comb begin
      mismatch_d = violation;
      err_d      = err_q;
      cnt_d      = cnt_q;
      pips_d     = pips_q;
      if (clr) begin
         err_d = 1'b0;
         cnt_d = '0;
      end else if (violation) begin
         err_d = 1'b1;
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
      if (!sel && is_legal(1'b0, result)) pips_d = face(result);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_result_q <= 3'b000;
         prev_button_q <= 1'b0;
         prev_sel_q    <= 1'b0;
         err_q         <= 1'b0;
         mismatch_q    <= 1'b0;
         cnt_q         <= '0;
         pips_q        <= 7'b0000000;
      end else begin
         prev_result_q <= result;
         prev_button_q <= button;
         prev_sel_q    <= sel;
         err_q         <= err_d;
         mismatch_q    <= mismatch_d;
         cnt_q         <= cnt_d;
         pips_q        <= pips_d;
      end
   end

   assign err       = err_q;
   assign mismatch  = mismatch_q;
   assign err_count = cnt_q;
   assign pips      = pips_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dotl_checker.sv
// Bench for dotl_checker: directed vector table, saturation / async-reset sequences,
// and randomized traffic compared against a list-based model of the legal sequences.
module tb_dotl_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sel = 1'b0, button = 1'b0, clr = 1'b0;
   logic [2:0] result = 3'd0;

   logic       err, mismatch, dbg_state;
   logic [7:0] err_count;
   logic [6:0] pips;
   logic       s_err, s_mismatch, s_dbg_state;
   logic [1:0] s_err_count;
   logic [6:0] s_pips;

   int n_checks = 0;
   int n_errors = 0;

   dotl_checker #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .sel(sel), .button(button), .result(result), .clr(clr),
      .err(err), .mismatch(mismatch), .err_count(err_count), .pips(pips),
      .dbg_state(dbg_state)
   );

   dotl_checker #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .sel(sel), .button(button), .result(result), .clr(clr),
      .err(s_err), .mismatch(s_mismatch), .err_count(s_err_count), .pips(s_pips),
      .dbg_state(s_dbg_state)
   );

   always #5 clk = ~clk;

   // Reference model: legal sequences as ordered lists, faces indexed by position.
   logic [2:0] dice_seq[6]    = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
   logic [2:0] traffic_seq[4] = '{3'b100, 3'b110, 3'b001, 3'b010};
   logic [6:0] face_tab[6]    = '{7'b0001000, 7'b1000001, 7'b1001001,
                                  7'b1100011, 7'b1101011, 7'b1110111};

   bit         m_have_ref;
   logic [2:0] m_prev_r;
   logic       m_prev_b, m_prev_s, m_mis, m_err;
   int         m_cnt;
   logic [6:0] m_pips;

   function automatic int seq_idx(input logic s, input logic [2:0] r);
      if (s) begin
         for (int i = 0; i < 4; i++) if (traffic_seq[i] == r) return i;
      end else begin
         for (int i = 0; i < 6; i++) if (dice_seq[i] == r) return i;
      end
      return -1;
   endfunction

   function automatic logic [2:0] model_expected(input logic s);
      int idx = seq_idx(s, m_prev_r);
      if (idx < 0) return s ? traffic_seq[0] : dice_seq[0];
      if (s) return traffic_seq[(idx + 1) % 4];
      if (m_prev_b) return dice_seq[(idx + 1) % 6];
      return m_prev_r;
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_have_ref = 0; m_prev_r = 3'd0; m_prev_b = 1'b0; m_prev_s = 1'b0;
      m_mis = 1'b0; m_err = 1'b0; m_cnt = 0; m_pips = 7'd0;
   endtask

   task automatic model_edge();
      bit         cmp;
      int         idx;
      logic [2:0] e;
      cmp = m_have_ref && (sel == m_prev_s);
      idx = seq_idx(sel, result);
      e   = model_expected(sel);
      m_mis = cmp && ((idx < 0) || (result != e));
      if (clr) begin
         m_err = 1'b0; m_cnt = 0;
      end else if (m_mis) begin
         m_err = 1'b1; m_cnt++;
      end
      if (!sel && idx >= 0) m_pips = face_tab[idx];
      m_prev_r = result; m_prev_b = button; m_prev_s = sel; m_have_ref = 1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic s, input logic b, input logic [2:0] r, input logic c);
      sel = s; button = b; result = r; clr = c;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, " mismatch"}, 32'(mismatch), 32'(m_mis));
      check({tag, " err"}, 32'(err), 32'(m_err));
      check({tag, " err_count"}, 32'(err_count), 32'(sat(m_cnt, 255)));
      check({tag, " sat_count"}, 32'(s_err_count), 32'(sat(m_cnt, 3)));
      check({tag, " pips"}, 32'(pips), 32'(m_pips));
   endtask

   typedef struct {
      logic       s;
      logic       b;
      logic [2:0] r;
      logic       c;
      logic       mis;
      logic       err;
      int         cnt;
      logic [6:0] pips;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic s, input logic b, input logic [2:0] r, input logic c,
                      input logic mis, input logic e, input int cnt, input logic [6:0] p);
      vec_t v;
      v.s = s; v.b = b; v.r = r; v.c = c; v.mis = mis; v.err = e; v.cnt = cnt; v.pips = p;
      tbl.push_back(v);
   endtask

   initial begin
      logic       rs, rb, rc;
      logic [2:0] rr;
      model_reset();

      // Dice roll through a full wrap.
      add(0,1,3'd1,0, 0,0,0, 7'b0001000);
      add(0,1,3'd2,0, 0,0,0, 7'b1000001);
      add(0,1,3'd3,0, 0,0,0, 7'b1001001);
      add(0,1,3'd4,0, 0,0,0, 7'b1100011);
      add(0,1,3'd5,0, 0,0,0, 7'b1101011);
      add(0,1,3'd6,0, 0,0,0, 7'b1110111);
      add(0,1,3'd1,0, 0,0,0, 7'b0001000);
      // Roll to 4, hold it, then an illegal step to 5.
      add(0,1,3'd2,0, 0,0,0, 7'b1000001);
      add(0,1,3'd3,0, 0,0,0, 7'b1001001);
      add(0,0,3'd4,0, 0,0,0, 7'b1100011);
      add(0,0,3'd4,0, 0,0,0, 7'b1100011);
      add(0,0,3'd5,0, 1,1,1, 7'b1101011);
      add(0,0,3'd5,0, 0,1,1, 7'b1101011);
      // Traffic cycle, button ignored, then a skipped phase.
      add(1,0,3'b100,0, 0,1,1, 7'b1101011);
      add(1,0,3'b110,0, 0,1,1, 7'b1101011);
      add(1,1,3'b001,0, 0,1,1, 7'b1101011);
      add(1,0,3'b010,0, 0,1,1, 7'b1101011);
      add(1,0,3'b100,0, 0,1,1, 7'b1101011);
      add(1,0,3'b001,0, 1,1,2, 7'b1101011);
      // Mode switch, illegal code, recovery, then clr racing a violation.
      add(0,1,3'd3,0, 0,1,2, 7'b1001001);
      add(0,1,3'd7,0, 1,1,3, 7'b1001001);
      add(0,0,3'd1,0, 0,1,3, 7'b0001000);
      add(0,1,3'd1,0, 0,1,3, 7'b0001000);
      add(0,1,3'd5,1, 1,0,0, 7'b1101011);
      add(0,1,3'd6,0, 0,0,0, 7'b1110111);

      #12;
      check("reset err", 32'(err), 32'd0);
      check("reset mismatch", 32'(mismatch), 32'd0);
      check("reset err_count", 32'(err_count), 32'd0);
      check("reset sat_count", 32'(s_err_count), 32'd0);
      check("reset pips", 32'(pips), 32'd0);
      check("reset state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].s, tbl[i].b, tbl[i].r, tbl[i].c);
         check($sformatf("vec%0d mismatch", i), 32'(mismatch), 32'(tbl[i].mis));
         check($sformatf("vec%0d err", i), 32'(err), 32'(tbl[i].err));
         check($sformatf("vec%0d err_count", i), 32'(err_count), 32'(tbl[i].cnt));
         check($sformatf("vec%0d sat_count", i), 32'(s_err_count), 32'(sat(tbl[i].cnt, 3)));
         check($sformatf("vec%0d pips", i), 32'(pips), 32'(tbl[i].pips));
      end

      // Repeated value while rolling: five violations, narrow counter pins at 3.
      for (int k = 1; k <= 5; k++) begin
         drive(0, 1, 3'd6, 0);
         check($sformatf("sat%0d mismatch", k), 32'(mismatch), 32'd1);
         check($sformatf("sat%0d err_count", k), 32'(err_count), 32'(k));
         check($sformatf("sat%0d sat_count", k), 32'(s_err_count), 32'(sat(k, 3)));
         check($sformatf("sat%0d sat_err", k), 32'(s_err), 32'd1);
      end

      // Reset asserted between edges must clear outputs without a clock edge.
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async err", 32'(err), 32'd0);
      check("async err_count", 32'(err_count), 32'd0);
      check("async sat_count", 32'(s_err_count), 32'd0);
      check("async pips", 32'(pips), 32'd0);
      check("async state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();

      // First sample after reset is a resync even when illegal.
      drive(0, 1, 3'd7, 0);
      check("post-reset mismatch", 32'(mismatch), 32'd0);
      check("post-reset pips", 32'(pips), 32'd0);

      for (int n = 0; n < 600; n++) begin
         rs = ($urandom_range(0, 15) == 0) ? ~sel : sel;
         rb = 1'($urandom_range(0, 1));
         rc = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 9) == 0) rr = 3'($urandom_range(0, 7));
         else                            rr = model_expected(rs);
         drive(rs, rb, rr, rc);
         check_model($sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
